grant_capture_fifo: RTL and testbench

- Downstream consumer of the 4-requester rotating-priority arbiter.
- Takes the arbiter's one-hot grant and the four requester payloads, and captures the granted payload with its requester ID into a small FIFO.
- Returns a same-cycle ack to the winning requester and presents captured entries to a shared sink over a valid/ready interface.
- Flags protocol errors when the grant is not one-hot.

---
 rtl/grant_capture_fifo.sv | 140 ++++++++++++++
 tb/tb_grant_capture_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/grant_capture_fifo.sv
// grant_capture_fifo
//   Downstream consumer of the 4-requester rotating-priority arbiter. It takes
//   the arbiter's one-hot grant, captures the granted requester's payload
//   together with its requester index into a small FIFO, and acknowledges the
//   winner in the same cycle. Captured entries go to a shared sink over a
//   first-word-fall-through valid/ready interface. A grant that is nonzero but
//   not one-hot is rejected and raises a sticky error flag.
//
// Optional feature: define GRANT_COUNT_EN to add grant_cnt, four 16-bit
//   saturating counters of captures per requester.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high; clears all state
//   gnt        in   [3:0]     one-hot grant from the arbiter, 0 = idle
//   req_data   in   [4*DW-1:0] requester payloads, requester i at [i*DW +: DW]
//   ack        out  [3:0]     equals gnt in a capturing cycle, else 0 (combinational)
//   full       out            FIFO holds DEPTH entries
//   out_valid  out            FIFO non-empty
//   out_ready  in             sink accepts the head entry
//   out_data   out  [DW-1:0]  head entry payload (holds last value while empty)
//   out_id     out  [1:0]     head entry requester index
//   count      out  [AW:0]    occupancy, 0..DEPTH
//   err        out            sticky flag for a non-one-hot nonzero grant
//   grant_cnt  out  [63:0]    per-requester capture counters (GRANT_COUNT_EN only)

module grant_capture_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      gnt,
  input  logic [4*DW-1:0] req_data,
  output logic [3:0]      ack,
  output logic            full,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_id,
  output logic [AW:0]     count,
  output logic            err
`ifdef GRANT_COUNT_EN
  ,
  output logic [4*16-1:0] grant_cnt
`endif
);

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } entry_t;

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  entry_t        held;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          gnt_ok;
  logic          capture;
  logic          pop;

  assign full      = (count == FULL_COUNT);
  assign out_valid = (count != '0);
  assign head      = mem[rd_ptr];

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_ok   = (gnt != 4'd0) && ((gnt & (gnt - 4'd1)) == 4'd0);
    // full is the registered value, so a same-cycle pop cannot make room for
    // a capture. The sink ignores the reset cycle, and so does the capture path.
    capture  = gnt_ok && !full && !reset;
    pop      = out_valid && out_ready;
    wr_entry = '0;
    case (gnt)
      4'b0001: wr_entry = '{id: 2'd0, data: req_data[0*DW +: DW]};
      4'b0010: wr_entry = '{id: 2'd1, data: req_data[1*DW +: DW]};
      4'b0100: wr_entry = '{id: 2'd2, data: req_data[2*DW +: DW]};
      4'b1000: wr_entry = '{id: 2'd3, data: req_data[3*DW +: DW]};
      default: wr_entry = '0;
    endcase
    ack = capture ? gnt : 4'd0;
  end

  // While empty, the outputs show the last popped entry, or zero after reset.
  assign out_data = out_valid ? head.data : held.data;
  assign out_id   = out_valid ? head.id   : held.id;

  // NOTE: the storage array has no reset. Its contents are only visible while
  // out_valid is set, and out_valid covers only slots that have been written.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= wr_entry;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      held   <= '0;
      err    <= 1'b0;
    end else begin
      if (capture) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        held   <= head;
      end
      case ({capture, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (gnt != 4'd0 && !gnt_ok) err <= 1'b1;
    end
  end

`ifdef GRANT_COUNT_EN
  logic [15:0] cnt_q [4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (capture && cnt_q[wr_entry.id] != 16'hFFFF) begin
      cnt_q[wr_entry.id] <= cnt_q[wr_entry.id] + 16'd1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_grant_capture_fifo.sv
// Self-checking bench for grant_capture_fifo (DW=8, DEPTH=4, AW=2).
// A table of directed vectors covers fill, drop-while-full, drain and hold,
// capture into an empty FIFO, full with pop in the same cycle, and the error
// grant. Hand-written sequences cover asynchronous reset, steady
// capture-and-pop with pointer wrap, and the optional grant counters.

module tb_grant_capture_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  gnt;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        full;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic [2:0]  count;
  logic        err;
`ifdef GRANT_COUNT_EN
  logic [63:0] grant_cnt;
`endif

  grant_capture_fifo #(.DW(8), .DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .gnt       (gnt),
    .req_data  (req_data),
    .ack       (ack),
    .full      (full),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .count     (count)
    ,
    .err       (err)
`ifdef GRANT_COUNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic       rdy;
    logic [3:0] ack;  // expected before the edge
    logic [2:0] cnt;  // expected after the edge, and the rest below
    logic       full;
    logic       vld;
    logic [7:0] od;
    logic [1:0] oid;
    logic       err;
  } vec_t;

  localparam int NV = 23;
  vec_t rows [NV];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " count"},     32'(count),     32'd0);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " full"},      32'(full),      32'd0);
    check({tag, " out_data"},  32'(out_data),  32'd0);
    check({tag, " out_id"},    32'(out_id),    32'd0);
    check({tag, " err"},       32'(err),       32'd0);
    check({tag, " ack"},       32'(ack),       32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] prev;

    // Requester payloads for the table: AA, BB, CC, DD for requesters 0..3.
    for (int i = 0; i < 5; i++)
      rows[i] = '{4'h0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
    rows[5]  = '{4'h1, 1'b0, 4'h1, 3'd1, 1'b0, 1'b1, 8'hAA, 2'd0, 1'b0};
    rows[6]  = '{4'h2, 1'b0, 4'h2, 3'd2, 1'b0, 1'b1, 8'hAA, 2'd0, 1'b0};
    rows[7]  = '{4'h4, 1'b0, 4'h4, 3'd3, 1'b0, 1'b1, 8'hAA, 2'd0, 1'b0};
    rows[8]  = '{4'h8, 1'b0, 4'h8, 3'd4, 1'b1, 1'b1, 8'hAA, 2'd0, 1'b0};
    rows[9]  = '{4'h1, 1'b0, 4'h0, 3'd4, 1'b1, 1'b1, 8'hAA, 2'd0, 1'b0}; // dropped
    rows[10] = '{4'h0, 1'b1, 4'h0, 3'd3, 1'b0, 1'b1, 8'hBB, 2'd1, 1'b0};
    rows[11] = '{4'h0, 1'b1, 4'h0, 3'd2, 1'b0, 1'b1, 8'hCC, 2'd2, 1'b0};
    rows[12] = '{4'h0, 1'b1, 4'h0, 3'd1, 1'b0, 1'b1, 8'hDD, 2'd3, 1'b0};
    rows[13] = '{4'h0, 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 8'hDD, 2'd3, 1'b0}; // holds last
    rows[14] = '{4'h0, 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 8'hDD, 2'd3, 1'b0};
    rows[15] = '{4'h4, 1'b1, 4'h4, 3'd1, 1'b0, 1'b1, 8'hCC, 2'd2, 1'b0}; // empty+capture
    rows[16] = '{4'h8, 1'b0, 4'h8, 3'd2, 1'b0, 1'b1, 8'hCC, 2'd2, 1'b0};
    rows[17] = '{4'h1, 1'b0, 4'h1, 3'd3, 1'b0, 1'b1, 8'hCC, 2'd2, 1'b0};
    rows[18] = '{4'h2, 1'b0, 4'h2, 3'd4, 1'b1, 1'b1, 8'hCC, 2'd2, 1'b0};
    rows[19] = '{4'h4, 1'b1, 4'h0, 3'd3, 1'b0, 1'b1, 8'hDD, 2'd3, 1'b0}; // full+pop
    rows[20] = '{4'h3, 1'b0, 4'h0, 3'd3, 1'b0, 1'b1, 8'hDD, 2'd3, 1'b1}; // bad grant
    rows[21] = '{4'h1, 1'b0, 4'h1, 3'd4, 1'b1, 1'b1, 8'hDD, 2'd3, 1'b1};
    rows[22] = '{4'h0, 1'b1, 4'h0, 3'd3, 1'b0, 1'b1, 8'hAA, 2'd0, 1'b1};

    reset     = 1'b1;
    gnt       = 4'h0;
    req_data  = 32'hDDCCBBAA;
    out_ready = 1'b0;
    #2;
    check_idle("reset");
    cycle();
    reset = 1'b0;
    #1;
    check_idle("post-reset");

    // Table-driven section.
    for (int i = 0; i < NV; i++) begin
      gnt       = rows[i].gnt;
      out_ready = rows[i].rdy;
      #1;
      check($sformatf("row%0d ack", i), 32'(ack), 32'(rows[i].ack));
      cycle();
      check($sformatf("row%0d count", i),     32'(count),     32'(rows[i].cnt));
      check($sformatf("row%0d full", i),      32'(full),      32'(rows[i].full));
      check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(rows[i].vld));
      check($sformatf("row%0d out_data", i),  32'(out_data),  32'(rows[i].od));
      check($sformatf("row%0d out_id", i),    32'(out_id),    32'(rows[i].oid));
      check($sformatf("row%0d err", i),       32'(err),       32'(rows[i].err));
    end

    // Asynchronous reset mid-operation: outputs clear without a clock edge.
    gnt       = 4'h0;
    out_ready = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check_idle("mid-reset");
    cycle();
    reset = 1'b0;
    #1;

    // Steady capture+pop: prime one entry, then capture and pop every cycle.
    gnt      = 4'h1;
    req_data = {4{8'h2F}};
    cycle();
    check("prime count", 32'(count), 32'd1);
    prev = 8'h2F;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      gnt      = 4'(1 << (k % 4));
      req_data = {4{8'(8'h30 + k)}};
      #1;
      check($sformatf("steady%0d ack", k),      32'(ack),      32'(gnt));
      check($sformatf("steady%0d pre head", k), 32'(out_data), 32'(prev));
      cycle();
      check($sformatf("steady%0d count", k),    32'(count),    32'd1);
      check($sformatf("steady%0d out_data", k), 32'(out_data), 32'(8'h30 + k));
      check($sformatf("steady%0d out_id", k),   32'(out_id),   32'(k % 4));
      prev = 8'(8'h30 + k);
    end
    gnt = 4'h0;
    cycle();
    check("steady drained", 32'(out_valid), 32'd0);

    // Per-requester capture counting: 3 from requester 2, 1 from requester 0,
    // then a dropped requester-2 grant while full.
    out_ready = 1'b0;
    do_reset();
    req_data = 32'hDDCCBBAA;
    for (int k = 0; k < 3; k++) begin
      gnt = 4'h4;
      cycle();
    end
    gnt = 4'h1;
    cycle();
    check("count burst full", 32'(full), 32'd1);
    gnt = 4'h4;
    #1;
    check("drop ack", 32'(ack), 32'd0);
    cycle();
    check("drop count", 32'(count), 32'd4);
`ifdef GRANT_COUNT_EN
    check("grant_cnt req2", 32'(grant_cnt[47:32]), 32'd3);
    check("grant_cnt req0", 32'(grant_cnt[15:0]),  32'd1);
`endif
    // Reset in the middle of the burst.
    gnt = 4'h0;
    #1;
    reset = 1'b1;
    #1;
    check_idle("burst-reset");
`ifdef GRANT_COUNT_EN
    check("grant_cnt cleared lo", grant_cnt[31:0],  32'd0);
    check("grant_cnt cleared hi", grant_cnt[63:32], 32'd0);
`endif
    cycle();
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
